// File: rtl/store_check_pkg.sv
// rtl/store_check_pkg.sv - shared types and default constants for the store checker
package store_check_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL
`ifdef STORE_CHECK_TIMEOUT_EN
        , ST_TIMEOUT
`endif
    } state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } log_entry_t;

    localparam logic [31:0] DEFAULT_PASS_ADR       = 32'd100;
    localparam logic [31:0] DEFAULT_PASS_DATA      = 32'd25;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/store_check_fifo.sv
// rtl/store_check_fifo.sv - DEPTH-entry log FIFO; push into a full FIFO succeeds only alongside a pop
module store_check_fifo
    import store_check_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  log_entry_t push_entry,
    input  logic       pop,
    output log_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    log_entry_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full, wr_ptr == rd_ptr: the slot being popped is reused by the simultaneous push.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/store_checker.sv
// rtl/store_checker.sv - CPU store logger with pass/fail signature detection; STORE_CHECK_TIMEOUT_EN adds a watchdog
module store_checker
    import store_check_pkg::*;
#(
    parameter int          DEPTH          = 8,
    parameter logic [31:0] PASS_ADR       = DEFAULT_PASS_ADR,
    parameter logic [31:0] PASS_DATA      = DEFAULT_PASS_DATA,
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_adr,
    output logic [31:0] log_data,
    output logic [15:0] store_count,
    output logic        overflow,
    output logic        done,
    output logic        pass,
    output logic        fail
);

    state_t     state;
    log_entry_t head;
    log_entry_t entry;
    logic       full;
    logic       empty;
    logic       accept;
    logic       pop;

    assign accept     = MemWrite && (state == ST_RUN);
    assign pop        = !empty && log_ready;
    assign entry.adr  = DataAdr;
    assign entry.data = WriteData;

    store_check_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_entry (entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

    assign log_valid = !empty;
    assign log_adr   = head.adr;
    assign log_data  = head.data;

    assign done = (state != ST_RUN);
    assign pass = (state == ST_PASS);
`ifdef STORE_CHECK_TIMEOUT_EN
    assign fail = (state == ST_FAIL) || (state == ST_TIMEOUT);

    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] wdog;
`else
    assign fail = (state == ST_FAIL);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            store_count <= '0;
            overflow    <= 1'b0;
`ifdef STORE_CHECK_TIMEOUT_EN
            wdog        <= '0;
`endif
        end else begin
            if (accept) begin
                if (store_count != 16'hFFFF) store_count <= store_count + 16'd1;
                if (full && !pop) overflow <= 1'b1;
            end
            // Signature store takes priority over a watchdog expiry on the same edge.
            if (state == ST_RUN) begin
                if (accept && (DataAdr == PASS_ADR)) begin
                    state <= (WriteData == PASS_DATA) ? ST_PASS : ST_FAIL;
                end
`ifdef STORE_CHECK_TIMEOUT_EN
                else if (wdog == WDOG_LAST) begin
                    state <= ST_TIMEOUT;
                end else begin
                    wdog <= wdog + 32'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_store_checker.sv
// tb/tb_store_checker.sv - directed self-checking bench for store_checker
module tb_store_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        log_ready;
    logic        log_valid;
    logic [31:0] log_adr;
    logic [31:0] log_data;
    logic [15:0] store_count;
    logic        overflow;
    logic        done;
    logic        pass;
    logic        fail;

    logic        to_log_valid;
    logic [31:0] to_log_adr;
    logic [31:0] to_log_data;
    logic [15:0] to_store_count;
    logic        to_overflow;
    logic        to_done;
    logic        to_pass;
    logic        to_fail;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    store_checker dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .log_valid   (log_valid),
        .log_ready   (log_ready),
        .log_adr     (log_adr),
        .log_data    (log_data),
        .store_count (store_count),
        .overflow    (overflow),
        .done        (done),
        .pass        (pass),
        .fail        (fail)
    );

    store_checker #(.TIMEOUT_CYCLES(20)) dut_to (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (1'b0),
        .DataAdr     (32'd0),
        .WriteData   (32'd0),
        .log_valid   (to_log_valid),
        .log_ready   (1'b1),
        .log_adr     (to_log_adr),
        .log_data    (to_log_data),
        .store_count (to_store_count),
        .overflow    (to_overflow),
        .done        (to_done),
        .pass        (to_pass),
        .fail        (to_fail)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        MemWrite  = 1'b0;
        log_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] a, input logic [31:0] d);
        check({tag, "_valid"}, 32'(log_valid), 32'd1);
        check({tag, "_adr"}, log_adr, a);
        check({tag, "_data"}, log_data, d);
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        log_ready = 1'b0;

        do_reset();
        check("rst_valid", 32'(log_valid), 32'd0);
        check("rst_count", 32'(store_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);

        // Watchdog instance: 19 idle cycles after reset, then the 20th.
        for (int i = 0; i < 19; i++) tick();
        check("to_done_19", 32'(to_done), 32'd0);
        tick();
`ifdef STORE_CHECK_TIMEOUT_EN
        check("to_done_20", 32'(to_done), 32'd1);
        check("to_fail_20", 32'(to_fail), 32'd1);
        check("to_pass_20", 32'(to_pass), 32'd0);
`else
        check("to_done_20", 32'(to_done), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("to_done_30", 32'(to_done), 32'd0);
`endif

        do_reset();
        store(32'd84, 32'd7);
        check("p1_valid", 32'(log_valid), 32'd1);
        check("p1_done", 32'(done), 32'd0);
        store(32'd100, 32'd25);
        check("p2_pass", 32'(pass), 32'd1);
        check("p2_done", 32'(done), 32'd1);
        check("p2_fail", 32'(fail), 32'd0);
        check("p2_count", 32'(store_count), 32'd2);
        pop_expect("p_e0", 32'd84, 32'd7);
        pop_expect("p_e1", 32'd100, 32'd25);
        check("p_empty", 32'(log_valid), 32'd0);

        do_reset();
        store(32'd100, 32'd26);
        check("f1_fail", 32'(fail), 32'd1);
        check("f1_pass", 32'(pass), 32'd0);
        check("f1_done", 32'(done), 32'd1);
        store(32'd100, 32'd25);
        check("f2_fail", 32'(fail), 32'd1);
        check("f2_pass", 32'(pass), 32'd0);
        check("f2_count", 32'(store_count), 32'd1);
        pop_expect("f_e0", 32'd100, 32'd26);
        check("f_empty", 32'(log_valid), 32'd0);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            store(32'(4 * i), 32'h100 + 32'(i));
            if (i == 7) check("o_ovf8", 32'(overflow), 32'd0);
        end
        check("o_ovf9", 32'(overflow), 32'd1);
        check("o_count", 32'(store_count), 32'd9);
        for (int i = 0; i < 8; i++) pop_expect("o_drain", 32'(4 * i), 32'h100 + 32'(i));
        check("o_empty", 32'(log_valid), 32'd0);

        do_reset();
        for (int i = 0; i < 8; i++) store(32'h40 + 32'(4 * i), 32'(i));
        log_ready = 1'b1;
        store(32'd200, 32'h55);
        log_ready = 1'b0;
        check("s_ovf", 32'(overflow), 32'd0);
        check("s_count", 32'(store_count), 32'd9);
        for (int i = 1; i < 8; i++) pop_expect("s_drain", 32'h40 + 32'(4 * i), 32'(i));
        pop_expect("s_last", 32'd200, 32'h55);
        check("s_empty", 32'(log_valid), 32'd0);

        do_reset();
        store(32'd8, 32'd1);
        store(32'd12, 32'd2);
        store(32'd100, 32'd25);
        check("r_pre_done", 32'(done), 32'd1);
        check("r_pre_count", 32'(store_count), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r_valid", 32'(log_valid), 32'd0);
        check("r_count", 32'(store_count), 32'd0);
        check("r_ovf", 32'(overflow), 32'd0);
        check("r_done", 32'(done), 32'd0);
        check("r_pass", 32'(pass), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_checker.md
STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the log FIFO entry count (power of two, at least 2).
REQ-002 The block SHALL have parameter PASS_ADR, default 32'd100, meaning the signature store address.
REQ-003 The block SHALL have parameter PASS_DATA, default 32'd25, meaning the signature value that marks success.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the watchdog limit in clock cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port MemWrite, input, 1 bit: the CPU store strobe.
REQ-008 The block SHALL have port DataAdr, input, 32 bits: the CPU store address.
REQ-009 The block SHALL have port WriteData, input, 32 bits: the CPU store data.
REQ-010 The block SHALL have port log_valid, output, 1 bit: the FIFO head is valid.
REQ-011 The block SHALL have port log_ready, input, 1 bit: the consumer accepts the head.
REQ-012 The block SHALL have port log_adr, output, 32 bits: the head address.
REQ-013 The block SHALL have port log_data, output, 32 bits: the head data.
REQ-014 The block SHALL have port store_count, output, 16 bits: the number of accepted stores.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag, at least one store was dropped.
REQ-016 The block SHALL have ports done, pass and fail, output, 1 bit each: the verdict flags.

Function
REQ-017 The FSM SHALL have states RUN, PASS, FAIL and, with the macro, TIMEOUT; PASS, FAIL and TIMEOUT are terminal until reset.
REQ-018 In RUN, each cycle with MemWrite=1 SHALL count as an accepted store; in terminal states stores SHALL be ignored (not logged, not counted).
REQ-019 An accepted store SHALL push {DataAdr, WriteData} into the FIFO; the entry becomes visible on log_valid/log_adr/log_data one cycle later.
REQ-020 A push into a full FIFO with no pop in the same cycle SHALL be dropped and SHALL set overflow.
REQ-021 A push and a pop in the same cycle on a full FIFO SHALL both take effect, with no overflow.
REQ-022 log_valid SHALL equal "FIFO not empty"; a pop occurs only on log_valid && log_ready; the head SHALL stay stable while log_ready=0.
REQ-023 Pointers SHALL wrap modulo DEPTH; entries SHALL be delivered in store order.
REQ-024 store_count SHALL increment by 1 per accepted store (including dropped ones) and saturate at 16'hFFFF.
REQ-025 An accepted store with DataAdr==PASS_ADR SHALL move the FSM to PASS if WriteData==PASS_DATA, else to FAIL, on the same edge; that store is logged and counted.
REQ-026 The outputs SHALL be decoded from registered state: done = (state != RUN); pass = (state == PASS); fail = (state == FAIL or TIMEOUT).
REQ-027 All outputs SHALL be registered or decoded from registered state only.

Reset
REQ-028 With reset=1 at a rising edge, the block SHALL set state to RUN, empty the FIFO, and clear store_count, overflow, the watchdog counter, log_valid, done, pass and fail.
REQ-029 Reset mid-operation SHALL discard all logged entries; log_adr and log_data SHALL then be don't-care while log_valid=0.

Configuration
REQ-030 With macro STORE_CHECK_TIMEOUT_EN defined, a cycle counter running in RUN SHALL move the FSM to TIMEOUT when it reaches TIMEOUT_CYCLES; a signature store on that same edge SHALL win.
REQ-031 Without STORE_CHECK_TIMEOUT_EN, the TIMEOUT state and counter SHALL be absent and RUN SHALL persist indefinitely without a signature store.

Structure
REQ-032 Package store_check_pkg SHALL hold the state enum, the log entry struct {adr, data}, and the default PASS_ADR, PASS_DATA and TIMEOUT_CYCLES constants.
REQ-033 The FIFO SHALL be a sub-module store_check_fifo (DEPTH-parameterised, push/pop/full/empty) instantiated once.

Verification
REQ-034 Reset 2 cycles, then stores (84,7) and (100,25) -> pass=1 and done=1 the cycle after the second store; log delivers (84,7) then (100,25); store_count=2.
REQ-035 Store (100,26), then store (100,25) -> fail=1 and pass=0 after the first; the second is ignored; store_count=1.
REQ-036 log_ready=0, DEPTH=8, nine stores to addresses 0..32 step 4 -> overflow=1 after the ninth; the drain yields the first eight in order; store_count=9.
REQ-037 FIFO full, and a store coincides with log_ready=1 -> overflow stays 0 and occupancy stays 8.
REQ-038 TIMEOUT_CYCLES=20, no stores -> with the macro, fail=1 and done=1 at cycle 20 after reset; without the macro, done stays 0.
REQ-039 Three entries logged, then reset pulsed -> log_valid=0, store_count=0, overflow=0 and done=0 on the next cycle.
